// File: rtl/common_pkg.sv
// Shared constants and types for the CRTC emulation: register indices,
// bus widths, the vertical FSM state type and the decoded register view.
package common_pkg;

  localparam int DATA_WIDTH          = 8;
  localparam int CRTC_ADDR_REG_WIDTH = 5;
  localparam logic [15:0] WB_CRTC_BASE = 16'hE880;

  localparam int CRTC_MA_WIDTH = 14;
  localparam int CRTC_RA_WIDTH = 5;

  localparam logic [4:0] CRTC_R0  = 5'd0;   // horizontal total - 1 (8 bits)
  localparam logic [4:0] CRTC_R1  = 5'd1;   // horizontal displayed (8 bits)
  localparam logic [4:0] CRTC_R2  = 5'd2;   // hsync position (8 bits)
  localparam logic [4:0] CRTC_R3  = 5'd3;   // sync widths, [7:4] v, [3:0] h (8 bits)
  localparam logic [4:0] CRTC_R4  = 5'd4;   // vertical total - 1 (7 bits)
  localparam logic [4:0] CRTC_R5  = 5'd5;   // vertical adjust (5 bits)
  localparam logic [4:0] CRTC_R6  = 5'd6;   // vertical displayed (7 bits)
  localparam logic [4:0] CRTC_R7  = 5'd7;   // vsync position (7 bits)
  localparam logic [4:0] CRTC_R8  = 5'd8;
  localparam logic [4:0] CRTC_R9  = 5'd9;   // scan lines per row - 1 (5 bits)
  localparam logic [4:0] CRTC_R10 = 5'd10;
  localparam logic [4:0] CRTC_R11 = 5'd11;
  localparam logic [4:0] CRTC_R12 = 5'd12;  // start address high (6 bits)
  localparam logic [4:0] CRTC_R13 = 5'd13;  // start address low (8 bits)
  localparam logic [4:0] CRTC_R14 = 5'd14;
  localparam logic [4:0] CRTC_R15 = 5'd15;
  localparam logic [4:0] CRTC_R16 = 5'd16;
  localparam logic [4:0] CRTC_R17 = 5'd17;

  typedef enum logic {V_ACTIVE = 1'b0, V_ADJUST = 1'b1} crtc_vstate_t;

  typedef struct packed {
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r9, r12, r13;
  } crtc_regfile_t;

  // Storable bits per register index; unimplemented indices store nothing.
  function automatic logic [7:0] crtc_reg_mask(input logic [4:0] idx);
    case (idx)
      CRTC_R0, CRTC_R1, CRTC_R2, CRTC_R3, CRTC_R13: return 8'hFF;
      CRTC_R4, CRTC_R6, CRTC_R7:                    return 8'h7F;
      CRTC_R5, CRTC_R9:                             return 8'h1F;
      CRTC_R12:                                     return 8'h3F;
      default:                                      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/crtc_regs.sv
// CRTC register file behind a Wishbone slave port with one-cycle ack;
// exposes the decoded register values to the timing logic.
module crtc_regs
  import common_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [CRTC_ADDR_REG_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]          wb_data_i,
  output logic [DATA_WIDTH-1:0]          wb_data_o,
  input  logic                           wb_we_i,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  output logic                           wb_ack_o,
  output crtc_regfile_t                  regs_o
);

  localparam int NREGS = 2 ** CRTC_ADDR_REG_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  req;

  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~ack_q;
    ack_d   = req;
    regs_d  = regs_q;
    rdata_d = '0;
    if (req) begin
      // Masking on write keeps unimplemented bits and registers reading as 0.
      if (wb_we_i)
        regs_d[wb_addr_i] = wb_data_i & crtc_reg_mask(wb_addr_i);
      else
        rdata_d = regs_q[wb_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_data_o = rdata_q;

  always_comb begin
    regs_o.r0  = regs_q[CRTC_R0];
    regs_o.r1  = regs_q[CRTC_R1];
    regs_o.r2  = regs_q[CRTC_R2];
    regs_o.r3  = regs_q[CRTC_R3];
    regs_o.r4  = regs_q[CRTC_R4];
    regs_o.r5  = regs_q[CRTC_R5];
    regs_o.r6  = regs_q[CRTC_R6];
    regs_o.r7  = regs_q[CRTC_R7];
    regs_o.r9  = regs_q[CRTC_R9];
    regs_o.r12 = regs_q[CRTC_R12];
    regs_o.r13 = regs_q[CRTC_R13];
  end

endmodule

// File: rtl/crtc_timing.sv
// 6545-style video timing: horizontal/scan/row counters, vertical FSM,
// sync and display-enable generation and refresh address.
module crtc_timing
  import common_pkg::*;
#(
  parameter int CHAR_COUNT_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           cclk_en_i,
  input  logic [CRTC_ADDR_REG_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]          wb_data_i,
  output logic [DATA_WIDTH-1:0]          wb_data_o,
  input  logic                           wb_we_i,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  output logic                           wb_ack_o,
  output logic                           h_sync_o,
  output logic                           v_sync_o,
  output logic                           de_o,
  output logic [CRTC_MA_WIDTH-1:0]       ma_o,
  output logic [CRTC_RA_WIDTH-1:0]       ra_o
);

  localparam int CW = CHAR_COUNT_WIDTH;

  crtc_regfile_t regs;

  crtc_regs u_regs (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_data_o (wb_data_o),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_ack_o  (wb_ack_o),
    .regs_o    (regs)
  );

  logic [CW-1:0]            h_q, h_d;
  logic [CRTC_RA_WIDTH-1:0] ra_q, ra_d;
  logic [6:0]               row_q, row_d;
  logic [7:0]               adj_q, adj_d;
  logic [4:0]               vs_q, vs_d;
  logic [CRTC_MA_WIDTH-1:0] ma_q, ma_d, row_start_q, row_start_d;
  crtc_vstate_t             state_q, state_d;
  logic                     hs_q, hs_d, vsync_q, vsync_d, de_q, de_d;

  logic                     line_end, row_end, last_row, frame_end;
  logic [CRTC_MA_WIDTH-1:0] start_addr;
  logic [7:0]               hs_off;

  always_comb begin
    h_d         = h_q;
    ra_d        = ra_q;
    row_d       = row_q;
    adj_d       = adj_q;
    vs_d        = vs_q;
    ma_d        = ma_q;
    row_start_d = row_start_q;
    state_d     = state_q;
    hs_d        = hs_q;
    vsync_d     = vsync_q;
    de_d        = de_q;

    start_addr = CRTC_MA_WIDTH'({regs.r12, regs.r13});
    line_end   = (h_q == CW'(regs.r0));
    row_end    = line_end && (state_q == V_ACTIVE) && ({3'b0, ra_q} == regs.r9);
    last_row   = ({1'b0, row_q} == regs.r4);
    frame_end  = (row_end && last_row && (regs.r5 == 8'd0)) ||
                 (line_end && (state_q == V_ADJUST) &&
                  (({1'b0, adj_q} + 9'd1) >= {1'b0, regs.r5}));
    hs_off     = '0;

    if (cclk_en_i) begin
      h_d  = line_end ? '0 : h_q + 1'b1;
      ma_d = ma_q + 1'b1;
      if (line_end) begin
        ma_d = row_start_q;
        ra_d = ra_q + 1'b1;
        if (state_q == V_ADJUST) adj_d = adj_q + 8'd1;
        if (row_end) begin
          ra_d        = '0;
          row_d       = row_q + 7'd1;
          ma_d        = row_start_q + CRTC_MA_WIDTH'(regs.r1);
          row_start_d = ma_d;
          if (last_row) begin
            state_d = V_ADJUST;
            adj_d   = '0;
          end
        end
        if (frame_end) begin
          state_d     = V_ACTIVE;
          row_d       = '0;
          ra_d        = '0;
          adj_d       = '0;
          ma_d        = start_addr;
          row_start_d = start_addr;
        end
        // VSYNC counts whole lines and deliberately ignores frame boundaries.
        if (state_d == V_ACTIVE && {1'b0, row_d} == regs.r7 && ra_d == '0)
          vs_d = (regs.r3[7:4] == 4'd0) ? 5'd16 : {1'b0, regs.r3[7:4]};
        else if (vs_q != 5'd0)
          vs_d = vs_q - 5'd1;
      end
      hs_off  = 8'(h_d) - regs.r2;
      hs_d    = hs_off < {4'b0, regs.r3[3:0]};
      vsync_d = (vs_d != 5'd0);
      de_d    = (h_d < CW'(regs.r1)) && ({1'b0, row_d} < regs.r6) && (state_d == V_ACTIVE);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h_q         <= '0;
      ra_q        <= '0;
      row_q       <= '0;
      adj_q       <= '0;
      vs_q        <= '0;
      ma_q        <= '0;
      row_start_q <= '0;
      state_q     <= V_ACTIVE;
      hs_q        <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      h_q         <= h_d;
      ra_q        <= ra_d;
      row_q       <= row_d;
      adj_q       <= adj_d;
      vs_q        <= vs_d;
      ma_q        <= ma_d;
      row_start_q <= row_start_d;
      state_q     <= state_d;
      hs_q        <= hs_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
    end
  end

  assign h_sync_o = hs_q;
  assign v_sync_o = vsync_q;
  assign de_o     = de_q;
  assign ma_o     = ma_q;
  assign ra_o     = ra_q;

endmodule
